// File: rtl/cmd_arb_pkg.sv
// Shared types and widths for the command arbiter and snd_cmd.
// START_W/LEN_W match the cmdROM address and length ports.
package cmd_arb_pkg;

    localparam int START_W = 5;
    localparam int LEN_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_RESP
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       valid
);

    localparam int IW = $clog2(NUM_REQ);

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!valid && req[j]) begin
                valid  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/cmd_arb.sv
// Round-robin sequencer sharing one snd_cmd among NUM_REQ requesters,
// with per-send response timeout and bounded retry.
module cmd_arb
    import cmd_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int TMO_W     = 20,
    parameter int TMO_CYC   = 1000000,
    parameter int MAX_RETRY = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [START_W*NUM_REQ-1:0] req_start,
    input  logic [LEN_W*NUM_REQ-1:0]   req_len,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         err,
    output logic                       busy,
    output logic [START_W-1:0]         cmd_start,
    output logic [LEN_W-1:0]           cmd_len,
    output logic                       send,
    input  logic                       resp_rcvd
);

    localparam int IW = $clog2(NUM_REQ);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
    localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

    state_t            state;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     owner;
    logic [2:0]        retry;
    logic [TMO_W-1:0]  timer;

    logic [NUM_REQ-1:0] a_gnt;
    logic [IW-1:0]      a_idx;
    logic               a_valid;
    logic [IW-1:0]      ptr_nxt;
    logic               tmo;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .req  (req),
        .ptr  (ptr),
        .gnt  (a_gnt),
        .idx  (a_idx),
        .valid(a_valid)
    );

    assign ptr_nxt = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign tmo     = (timer == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            retry     <= '0;
            timer     <= '0;
            grant     <= '0;
            done      <= '0;
            err       <= '0;
            busy      <= 1'b0;
            send      <= 1'b0;
            cmd_start <= '0;
            cmd_len   <= '0;
        end else begin
            send <= 1'b0;
            done <= '0;
            err  <= '0;
            unique case (state)
                IDLE: begin
                    if (a_valid) begin
                        grant     <= a_gnt;
                        owner     <= a_idx;
                        busy      <= 1'b1;
                        cmd_start <= req_start[START_W*int'(a_idx) +: START_W];
                        cmd_len   <= req_len[LEN_W*int'(a_idx) +: LEN_W];
                        retry     <= '0;
                        send      <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    timer <= '0;
                    state <= WAIT_RESP;
                end
                WAIT_RESP: begin
                    timer <= timer + 1'b1;
                    // A response on the timeout cycle still counts as success.
                    if (resp_rcvd) begin
                        done  <= grant;
                        grant <= '0;
                        busy  <= 1'b0;
                        ptr   <= ptr_nxt;
                        state <= IDLE;
                    end else if (tmo) begin
                        if (retry < RETRY_MAX) begin
                            retry <= retry + 1'b1;
                            send  <= 1'b1;
                            state <= SEND;
                        end else begin
                            err   <= grant;
                            grant <= '0;
                            busy  <= 1'b0;
                            ptr   <= ptr_nxt;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
